// File: rtl/svc_soc_mem_arb.sv
// svc_soc_mem_arb: two-requester arbiter (CPU data port, debug/loader port)
// in front of a single-port DMEM.
// Grants are combinational and at most one is issued per cycle. Debug
// requests are bounded in wait by MAX_WAIT. dbg_hold blocks all CPU grants.
// Read data returns one cycle after the read is granted.
// Optional build macro: SVC_SOC_MEM_ARB_STATS_EN adds the 32-bit grant and
// conflict counters stat_cpu_grants, stat_dbg_grants and stat_conflicts.
module svc_soc_mem_arb #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_req_valid,
  output logic            cpu_req_ready,
  input  logic [AW-1:0]   cpu_req_addr,
  input  logic            cpu_req_we,
  input  logic [DW-1:0]   cpu_req_wdata,
  input  logic [DW/8-1:0] cpu_req_wstrb,
  output logic            cpu_rsp_valid,
  output logic [DW-1:0]   cpu_rsp_rdata,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic [AW-1:0]   dbg_req_addr,
  input  logic            dbg_req_we,
  input  logic [DW-1:0]   dbg_req_wdata,
  input  logic [DW/8-1:0] dbg_req_wstrb,
  output logic            dbg_rsp_valid,
  output logic [DW-1:0]   dbg_rsp_rdata,
  input  logic            dbg_hold,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
`ifdef SVC_SOC_MEM_ARB_STATS_EN
  ,
  output logic [31:0]     stat_cpu_grants,
  output logic [31:0]     stat_dbg_grants,
  output logic [31:0]     stat_conflicts
`endif
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_CPU,
    RSP_DBG
  } rsp_owner_t;

  rsp_owner_t rsp_owner, rsp_owner_nxt;
  logic [7:0] wait_cnt;
  logic       dbg_force;
  logic       cpu_grant;
  logic       dbg_grant;

  // Grant decision: hold > starvation override > CPU > idle-CPU debug.
  // Grants are gated by rst_n so that both ready outputs read 0 while reset
  // is asserted, even though they are combinational.
  always_comb begin
    dbg_force = dbg_req_valid && (wait_cnt == MAX_W);
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (rst_n) begin
      if (dbg_hold) begin
        dbg_grant = dbg_req_valid;
      end else if (dbg_force) begin
        dbg_grant = 1'b1;
      end else if (cpu_req_valid) begin
        cpu_grant = 1'b1;
      end else begin
        dbg_grant = dbg_req_valid;
      end
    end
  end

  assign cpu_req_ready = cpu_grant;
  assign dbg_req_ready = dbg_grant;
  assign mem_en        = cpu_grant | dbg_grant;

  // Route the granted request onto the memory port; reads drive zero strobes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (dbg_grant) begin
      mem_addr  = dbg_req_addr;
      mem_wdata = dbg_req_wdata;
      mem_wstrb = dbg_req_we ? dbg_req_wstrb : '0;
    end else if (cpu_grant) begin
      mem_addr  = cpu_req_addr;
      mem_wdata = cpu_req_wdata;
      mem_wstrb = cpu_req_we ? cpu_req_wstrb : '0;
    end
  end

  // Debug starvation counter: counts lost cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!dbg_req_valid || dbg_grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_W) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Response owner register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner <= RSP_NONE;
    end else begin
      rsp_owner <= rsp_owner_nxt;
    end
  end

  // Next owner: the port whose read was accepted this cycle, if any.
  always_comb begin
    rsp_owner_nxt = RSP_NONE;
    if (cpu_grant && !cpu_req_we) begin
      rsp_owner_nxt = RSP_CPU;
    end else if (dbg_grant && !dbg_req_we) begin
      rsp_owner_nxt = RSP_DBG;
    end
  end

  assign cpu_rsp_valid = (rsp_owner == RSP_CPU);
  assign dbg_rsp_valid = (rsp_owner == RSP_DBG);
  assign cpu_rsp_rdata = mem_rdata;
  assign dbg_rsp_rdata = mem_rdata;

`ifdef SVC_SOC_MEM_ARB_STATS_EN
  // Free-running statistics counters, wrapping at 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpu_grants <= '0;
      stat_dbg_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (cpu_grant) stat_cpu_grants <= stat_cpu_grants + 32'd1;
      if (dbg_grant) stat_dbg_grants <= stat_dbg_grants + 32'd1;
      if (cpu_req_valid && dbg_req_valid) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_svc_soc_mem_arb.sv
// Testbench for svc_soc_mem_arb: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the arbitration rules
// and of the memory contents.
module tb_svc_soc_mem_arb;

  localparam int unsigned AW       = 10;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DEPTH    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_rsp_valid;
  logic [AW-1:0] cpu_req_addr;
  logic [31:0]   cpu_req_wdata, cpu_rsp_rdata;
  logic [3:0]    cpu_req_wstrb;
  logic          dbg_req_valid, dbg_req_ready, dbg_req_we, dbg_rsp_valid;
  logic [AW-1:0] dbg_req_addr;
  logic [31:0]   dbg_req_wdata, dbg_rsp_rdata;
  logic [3:0]    dbg_req_wstrb;
  logic          dbg_hold;
  logic          mem_en;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
`ifdef SVC_SOC_MEM_ARB_STATS_EN
  logic [31:0]   stat_cpu_grants, stat_dbg_grants, stat_conflicts;
`endif

  always #5 clk = ~clk;

  svc_soc_mem_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_addr(dbg_req_addr), .dbg_req_we(dbg_req_we),
    .dbg_req_wdata(dbg_req_wdata), .dbg_req_wstrb(dbg_req_wstrb),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
    .dbg_hold(dbg_hold),
    .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef SVC_SOC_MEM_ARB_STATS_EN
    , .stat_cpu_grants(stat_cpu_grants), .stat_dbg_grants(stat_dbg_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  // Environment DMEM: synchronous single-port RAM with byte enables.
  logic [31:0] dmem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wstrb == 4'h0) mem_rdata <= dmem[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) dmem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          m_wait;
  bit          m_pend_c, m_pend_d;
  logic [31:0] m_pend_data;
  logic [31:0] m_sc, m_sd, m_sx;

  // Observations from the last step, for directed checks.
  bit          obs_c, obs_d, obs_crv, obs_drv;
  logic [31:0] obs_crd, obs_drd;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model.
  task automatic step();
    bit eg_c, eg_d;
    logic [AW-1:0] a;
    bit we;
    logic [3:0] ws;
    logic [31:0] wd;
    @(negedge clk);
    if (!rst_n) begin
      m_pend_c = 0; m_pend_d = 0; m_wait = 0;
      m_sc = 0; m_sd = 0; m_sx = 0;
    end
    eg_c = 0; eg_d = 0;
    if (rst_n) begin
      if (dbg_hold) eg_d = dbg_req_valid;
      else if (dbg_req_valid && m_wait == MAX_WAIT) eg_d = 1;
      else if (cpu_req_valid) eg_c = 1;
      else eg_d = dbg_req_valid;
    end
    check("cpu_ready", 32'(cpu_req_ready), 32'(eg_c));
    check("dbg_ready", 32'(dbg_req_ready), 32'(eg_d));
    check("mem_en", 32'(mem_en), 32'(eg_c | eg_d));
    check("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(m_pend_c));
    check("dbg_rsp_valid", 32'(dbg_rsp_valid), 32'(m_pend_d));
    if (m_pend_c) check("cpu_rdata", cpu_rsp_rdata, m_pend_data);
    if (m_pend_d) check("dbg_rdata", dbg_rsp_rdata, m_pend_data);
`ifdef SVC_SOC_MEM_ARB_STATS_EN
    check("stat_cpu", stat_cpu_grants, m_sc);
    check("stat_dbg", stat_dbg_grants, m_sd);
    check("stat_conf", stat_conflicts, m_sx);
`endif
    obs_c = cpu_req_ready; obs_d = dbg_req_ready;
    obs_crv = cpu_rsp_valid; obs_drv = dbg_rsp_valid;
    obs_crd = cpu_rsp_rdata; obs_drd = dbg_rsp_rdata;

    m_pend_c = 0; m_pend_d = 0;
    if (eg_c || eg_d) begin
      a  = eg_d ? dbg_req_addr  : cpu_req_addr;
      we = eg_d ? dbg_req_we    : cpu_req_we;
      ws = eg_d ? dbg_req_wstrb : cpu_req_wstrb;
      wd = eg_d ? dbg_req_wdata : cpu_req_wdata;
      check("mem_addr", 32'(mem_addr), 32'(a));
      check("mem_wstrb", 32'(mem_wstrb), we ? 32'(ws) : 32'h0);
      if (we && ws != 0) check("mem_wdata", mem_wdata, wd);
      if (!we) begin
        m_pend_data = ref_mem[a];
        m_pend_c = eg_c; m_pend_d = eg_d;
      end else begin
        for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    if (rst_n) begin
      if (dbg_req_valid && !eg_d) m_wait = (m_wait >= MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      else m_wait = 0;
      if (eg_c) m_sc++;
      if (eg_d) m_sd++;
      if (cpu_req_valid && dbg_req_valid) m_sx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    cpu_req_valid = v; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = d; cpu_req_wstrb = s;
  endtask

  task automatic set_dbg(input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    dbg_req_valid = v; dbg_req_we = we; dbg_req_addr = a; dbg_req_wdata = d; dbg_req_wstrb = s;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      dmem[i]    = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end
    mem_rdata = '0;
    m_wait = 0; m_pend_c = 0; m_pend_d = 0; m_pend_data = '0;
    m_sc = 0; m_sd = 0; m_sx = 0;
    rst_n = 1'b0; dbg_hold = 1'b0;
    set_cpu(1, 0, 10'h001, 0, 0);
    set_dbg(1, 0, 10'h002, 0, 0);

    // Reset state, with both requests asserted.
    step();
    check("rst_cpu_ready", 32'(obs_c), 0);
    check("rst_dbg_ready", 32'(obs_d), 0);
    rst_n = 1'b1;
    set_cpu(0, 0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    step();

    // CPU only: write then read back.
    set_cpu(1, 1, 10'h010, 32'hDEADBEEF, 4'hF); step();
    set_cpu(1, 0, 10'h010, 0, 0); step();
    set_cpu(0, 0, 0, 0, 0); step();
    check("cpu_rd_valid", 32'(obs_crv), 1);
    check("cpu_rd_data", obs_crd, 32'hDEADBEEF);
    check("cpu_rd_dbgvalid", 32'(obs_drv), 0);

    // Conflict: 10 dual-read cycles, debug forced on cycles 4 and 9.
    set_cpu(1, 0, 10'h020, 0, 0);
    set_dbg(1, 0, 10'h021, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("conf_dbg_win", 32'(obs_d), (i == 4 || i == 9) ? 32'd1 : 32'd0);
    end
    set_cpu(0, 0, 0, 0, 0); set_dbg(0, 0, 0, 0, 0); step();

    // dbg_hold with both valid for 3 cycles, then release.
    dbg_hold = 1'b1;
    set_cpu(1, 0, 10'h030, 0, 0);
    set_dbg(1, 0, 10'h031, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_cpu_ready", 32'(obs_c), 0);
    end
    dbg_hold = 1'b0; set_dbg(0, 0, 0, 0, 0); step();
    check("hold_release_cpu", 32'(obs_c), 1);

    // dbg_hold rising while a CPU read is in flight.
    set_cpu(0, 0, 0, 0, 0); step();
    set_cpu(1, 0, 10'h010, 0, 0); step();
    dbg_hold = 1'b1; set_cpu(0, 0, 0, 0, 0); step();
    check("hold_inflight_rsp", 32'(obs_crv), 1);
    dbg_hold = 1'b0;

    // Byte strobes and zero-strobe write.
    set_cpu(1, 1, 10'h005, 32'h11223344, 4'hF); step();
    set_cpu(1, 1, 10'h005, 32'h000000AA, 4'h1); step();
    set_cpu(1, 1, 10'h005, 32'hFFFFFFFF, 4'h0); step();
    set_cpu(1, 0, 10'h005, 0, 0); step();
    check("wstrb0_no_rsp", 32'(obs_crv), 0);
    set_cpu(0, 0, 0, 0, 0); step();
    check("bytestrobe_data", obs_crd, 32'h112233AA);

    // Reset in the cycle after a CPU read grant.
    set_cpu(1, 0, 10'h010, 0, 0); step();
    rst_n = 1'b0; step();
    check("rst_mid_rsp", 32'(obs_crv), 0);
    check("rst_mid_mem_en", 32'(mem_en), 0);
    rst_n = 1'b1; step();
    check("post_rst_grant", 32'(obs_c), 1);
    set_cpu(0, 0, 0, 0, 0); step();
    check("post_rst_data", obs_crd, 32'hDEADBEEF);

    // Stats pattern: 6 CPU-only cycles, 4 dual cycles (from a fresh reset).
    rst_n = 1'b0; step(); rst_n = 1'b1;
    set_cpu(1, 0, 10'h040, 0, 0);
    for (int i = 0; i < 6; i++) step();
    set_dbg(1, 0, 10'h041, 0, 0);
    for (int i = 0; i < 4; i++) step();
    set_cpu(0, 0, 0, 0, 0); set_dbg(0, 0, 0, 0, 0); step();
`ifdef SVC_SOC_MEM_ARB_STATS_EN
    check("stats_cpu10", stat_cpu_grants, 32'd10);
    check("stats_dbg0", stat_dbg_grants, 32'd0);
    check("stats_conf4", stat_conflicts, 32'd4);
`endif

    // Randomized traffic; requests are held stable until granted.
    for (int n = 0; n < 600; n++) begin
      if (!cpu_req_valid && $urandom_range(0, 2) != 0)
        set_cpu(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, 4'($urandom));
      if (!dbg_req_valid && $urandom_range(0, 3) == 0)
        set_dbg(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, 4'($urandom));
      if ($urandom_range(0, 15) == 0) dbg_hold = ~dbg_hold;
      step();
      if (obs_c) cpu_req_valid = 1'b0;
      if (obs_d) dbg_req_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
